// File: rtl/sa_ctrl.sv
// rtl/sa_ctrl.sv - weight-stationary systolic array sequencer
// Loads a weight tile, streams skewed activations, and times per-column result strobes.
module sa_ctrl #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int VEC_W      = 8,
  parameter int SETTLE     = 2 * N,
  parameter int RES_LAT    = N + 1,
  localparam int AW        = $clog2(N)
) (
  input  logic                    SA_clk,
  input  logic                    SA_rst,
  input  logic                    start,
  input  logic [VEC_W-1:0]        cfg_num_vec,
  input  logic                    cfg_skip_wload,
  output logic                    busy,
  output logic                    done,
  output logic                    w_rd_en,
  output logic [AW-1:0]           w_rd_addr,
  input  logic [N*DATA_WIDTH-1:0] w_rd_data,
  output logic                    arr_en_up,
  output logic [N*DATA_WIDTH-1:0] arr_data_up,
  output logic                    a_rd_en,
  output logic [VEC_W-1:0]        a_rd_addr,
  input  logic [N*DATA_WIDTH-1:0] a_rd_data,
  output logic [N-1:0]            arr_en_left,
  output logic [N*DATA_WIDTH-1:0] arr_data_left,
  output logic [N-1:0]            res_valid
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int CMAX = max2(max2(N, SETTLE), max2(RES_LAT + N, 1 << VEC_W));
  localparam int CW   = $clog2(CMAX + 1);
  // One shift register serves both the row skew enables and the column result strobes.
  localparam int L    = RES_LAT + N - 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_WSETTLE, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [VEC_W-1:0] m_q;
  logic             skip_q;
  logic [L-1:0]     en_sh;

  always_ff @(posedge SA_clk) begin
    if (SA_rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      m_q    <= '0;
      skip_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == S_IDLE && start) begin
        m_q    <= cfg_num_vec;
        skip_q <= cfg_skip_wload;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt + CW'(1);
    busy      = 1'b0;
    done      = 1'b0;
    w_rd_en   = 1'b0;
    w_rd_addr = '0;
    a_rd_en   = 1'b0;
    a_rd_addr = '0;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (start) begin
          if (!cfg_skip_wload)        state_nx = S_WLOAD;
          else if (cfg_num_vec != '0) state_nx = S_COMPUTE;
          else                        state_nx = S_DONE;
        end
      end
      S_WLOAD: begin
        busy      = 1'b1;
        w_rd_en   = 1'b1;
        w_rd_addr = AW'(N - 1) - cnt[AW-1:0];
        if (cnt == CW'(N - 1)) begin
          cnt_nx   = '0;
          state_nx = S_WSETTLE;
        end
      end
      S_WSETTLE: begin
        busy = 1'b1;
        if (cnt == CW'(SETTLE - 1)) begin
          cnt_nx   = '0;
          state_nx = (m_q != '0) ? S_COMPUTE : S_DONE;
        end
      end
      S_COMPUTE: begin
        busy      = 1'b1;
        a_rd_en   = 1'b1;
        a_rd_addr = cnt[VEC_W-1:0];
        if (cnt == CW'(m_q) - CW'(1)) begin
          cnt_nx   = '0;
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (cnt == CW'(L - 1)) begin
          cnt_nx   = '0;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        cnt_nx   = '0;
        state_nx = S_IDLE;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge SA_clk) begin
    if (SA_rst) begin
      en_sh     <= '0;
      arr_en_up <= 1'b0;
    end else begin
      en_sh     <= {en_sh[L-2:0], a_rd_en};
      arr_en_up <= w_rd_en;
    end
  end

  assign arr_en_left = en_sh[N-1:0];
  assign res_valid   = en_sh[RES_LAT+N-2:RES_LAT-1];
  // Data is gated by its enable so nothing but zeros leaves the block outside a valid slot.
  assign arr_data_up = arr_en_up ? w_rd_data : '0;

  for (genvar r = 0; r < N; r++) begin : g_row
    if (r == 0) begin : g_direct
      assign arr_data_left[DATA_WIDTH-1:0] = arr_en_left[0] ? a_rd_data[DATA_WIDTH-1:0] : '0;
    end else begin : g_skew
      logic [DATA_WIDTH-1:0] pipe [r];
      always_ff @(posedge SA_clk) begin
        if (SA_rst) begin
          for (int i = 0; i < r; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= a_rd_data[r*DATA_WIDTH +: DATA_WIDTH];
          for (int i = 1; i < r; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign arr_data_left[r*DATA_WIDTH +: DATA_WIDTH] = arr_en_left[r] ? pipe[r-1] : '0;
    end
  end

endmodule

// File: tb/tb_sa_ctrl.sv
// tb/tb_sa_ctrl.sv - self-checking bench for sa_ctrl against a job-timeline model
module tb_sa_ctrl;
  localparam int N = 4, DW = 32, VEC_W = 8, SETTLE = 2 * N, RES_LAT = N + 1, AW = 2;
  localparam int HMAX = 16384;

  logic              SA_clk, SA_rst, start, cfg_skip_wload;
  logic [VEC_W-1:0]  cfg_num_vec;
  logic              busy, done, w_rd_en, arr_en_up, a_rd_en;
  logic [AW-1:0]     w_rd_addr;
  logic [VEC_W-1:0]  a_rd_addr;
  logic [N*DW-1:0]   w_rd_data, a_rd_data, arr_data_up, arr_data_left;
  logic [N-1:0]      arr_en_left, res_valid;

  sa_ctrl #(.N(N), .DATA_WIDTH(DW), .VEC_W(VEC_W), .SETTLE(SETTLE), .RES_LAT(RES_LAT)) dut (
    .SA_clk(SA_clk), .SA_rst(SA_rst), .start(start), .cfg_num_vec(cfg_num_vec),
    .cfg_skip_wload(cfg_skip_wload), .busy(busy), .done(done), .w_rd_en(w_rd_en),
    .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data), .arr_en_up(arr_en_up),
    .arr_data_up(arr_data_up), .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr),
    .a_rd_data(a_rd_data), .arr_en_left(arr_en_left), .arr_data_left(arr_data_left),
    .res_valid(res_valid)
  );

  initial SA_clk = 1'b0;
  always #5 SA_clk = ~SA_clk;

  int cyc = 0;
  always @(posedge SA_clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge SA_clk) begin
    #1;
    w_rd_data = {$urandom, $urandom, $urandom, $urandom};
    a_rd_data = {$urandom, $urandom, $urandom, $urandom};
  end

  // Model: the most recent accepted job, described only by its start cycle and config.
  bit j_valid = 0, seen_rst = 0, chk_en = 0;
  int j_s, j_skip, j_m, j_kill, idle_from = 0;
  logic [N*DW-1:0] a_hist [HMAX];

  function automatic bit aen(input int x, input int c0, input int m);
    return (x >= c0) && (x < c0 + m);
  endfunction

  always @(negedge SA_clk) begin : cmp
    int t, c0, dt, e_waddr, e_aaddr;
    bit alive, e_w, e_up, e_a;
    logic [N-1:0] e_left, e_rv;
    logic [N*DW-1:0] e_dl;
    t = cyc;
    if (t < HMAX) begin
      a_hist[t] = a_rd_data;
      if (chk_en) begin
        alive   = j_valid && (t <= j_kill);
        c0      = j_s + 1 + (j_skip != 0 ? 0 : N + SETTLE);
        dt      = (j_m == 0) ? c0 : c0 + j_m + RES_LAT + N - 1;
        e_w     = alive && j_skip == 0 && t >= j_s + 1 && t <= j_s + N;
        e_waddr = e_w ? N - 1 - (t - j_s - 1) : 0;
        e_up    = alive && j_skip == 0 && t >= j_s + 2 && t <= j_s + N + 1;
        e_a     = alive && aen(t, c0, j_m);
        e_aaddr = e_a ? t - c0 : 0;
        e_dl    = '0;
        for (int r = 0; r < N; r++) begin
          e_left[r] = alive && aen(t - 1 - r, c0, j_m);
          e_rv[r]   = alive && aen(t - RES_LAT - r, c0, j_m);
          if (e_left[r]) e_dl[r*DW +: DW] = a_hist[t-r][r*DW +: DW];
        end
        chk("busy", busy, alive && t > j_s && t < dt);
        chk("done", done, alive && t == dt);
        chk("w_rd_en", w_rd_en, e_w);
        chk("w_rd_addr", w_rd_addr, e_waddr);
        chk("arr_en_up", arr_en_up, e_up);
        chk("arr_data_up", arr_data_up, e_up ? w_rd_data : '0);
        chk("a_rd_en", a_rd_en, e_a);
        chk("a_rd_addr", a_rd_addr, e_aaddr);
        chk("arr_en_left", arr_en_left, e_left);
        chk("arr_data_left", arr_data_left, e_dl);
        chk("res_valid", res_valid, e_rv);
      end
      if (SA_rst) begin
        if (j_valid && j_kill > t) j_kill = t;
        idle_from = t + 1;
        seen_rst  = 1;
      end else if (seen_rst && start && t >= idle_from) begin
        j_valid = 1;
        j_s     = t;
        j_skip  = cfg_skip_wload;
        j_m     = cfg_num_vec;
        j_kill  = 32'h7fffffff;
        c0      = j_s + 1 + (j_skip != 0 ? 0 : N + SETTLE);
        idle_from = ((j_m == 0) ? c0 : c0 + j_m + RES_LAT + N - 1) + 1;
      end
      if (seen_rst) chk_en = 1;
    end
  end

  task automatic step();
    @(posedge SA_clk);
    #1;
  endtask

  task automatic run_job(input bit skip, input int m, input int exp_off, input int exp_w,
                         input bit poke);
    int s, nw, na, dcyc;
    step();
    s = cyc;
    start = 1'b1; cfg_num_vec = VEC_W'(m); cfg_skip_wload = skip;
    step();
    start = 1'b0; cfg_num_vec = VEC_W'($urandom); cfg_skip_wload = $urandom_range(0, 1);
    nw = 0; na = 0; dcyc = -1;
    for (int i = 0; i < 400 && dcyc < 0; i++) begin
      if (poke && cyc == s + 6) begin start = 1'b1; cfg_num_vec = 7; cfg_skip_wload = 1'b1; end
      if (poke && cyc == s + 7) start = 1'b0;
      if (w_rd_en) nw++;
      if (a_rd_en) na++;
      if (done) dcyc = cyc;
      else step();
    end
    chk("done_offset", dcyc - s, exp_off);
    chk("w_rd_count", nw, exp_w);
    chk("a_rd_count", na, m);
  endtask

  initial begin
    int s;
    SA_rst = 1'b1; start = $urandom_range(0, 1); cfg_num_vec = VEC_W'($urandom);
    cfg_skip_wload = $urandom_range(0, 1);
    repeat (2) begin
      step();
      start = $urandom_range(0, 1); cfg_num_vec = VEC_W'($urandom);
    end
    step();
    SA_rst = 1'b0; start = 1'b0;

    run_job(0, 3, 24, 4, 0);
    run_job(1, 1, 10, 0, 0);
    run_job(1, 0, 1, 0, 0);
    run_job(0, 0, 13, 4, 0);
    run_job(0, 3, 24, 4, 1);
    // start in DONE is ignored; the request held into IDLE launches a skip job
    start = 1'b1; cfg_num_vec = 1; cfg_skip_wload = 1'b1;
    step();
    step();
    start = 1'b0;
    chk("idle_accept_busy", busy, 1'b1);
    chk("idle_accept_a_rd_en", a_rd_en, 1'b1);
    repeat (12) step();

    s = cyc + 1;
    start = 1'b0;
    step();
    start = 1'b1; cfg_num_vec = 3; cfg_skip_wload = 1'b0;
    step();
    start = 1'b0;
    while (cyc < s + 14) step();
    SA_rst = 1'b1;
    step();
    SA_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_en_left", arr_en_left, '0);
      chk("post_rst_res_valid", res_valid, '0);
      step();
    end
    while (cyc < s + 19) step();
    run_job(0, 3, 24, 4, 0);
    run_job(1, 255, 264, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step();
      SA_rst = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 5) == 0);
      cfg_num_vec = ($urandom_range(0, 19) == 0) ? VEC_W'($urandom_range(0, 255))
                                                 : VEC_W'($urandom_range(0, 12));
      cfg_skip_wload = $urandom_range(0, 1);
    end
    SA_rst = 1'b0; start = 1'b0;
    repeat (300) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
